// File: rtl/exu_cal_arb_pkg.sv
// Shared definitions for the calculator arbiter: FSM state encodings, opcode-bundle width, id width.
// The backtick-defines below can be overridden from the command line; the guards keep earlier definitions.
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 16
`endif
`ifndef CIRNO_CALARB_IDLE
`define CIRNO_CALARB_IDLE  2'd0
`endif
`ifndef CIRNO_CALARB_ISSUE
`define CIRNO_CALARB_ISSUE 2'd1
`endif
`ifndef CIRNO_CALARB_WAIT
`define CIRNO_CALARB_WAIT  2'd2
`endif

package exu_cal_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = `CIRNO_CALARB_IDLE,
      ST_ISSUE = `CIRNO_CALARB_ISSUE,
      ST_WAIT  = `CIRNO_CALARB_WAIT
   } cal_arb_state_e;

   // Requester index width; a single requester still needs a 1-bit id port.
   function automatic int cal_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/exu_rr_pick.sv
// Combinational rotating picker: first set request at or above ptr, wrapping; zero latency, no state.
// Returns a one-hot grant plus the encoded winner index (both zero when nothing requests).
module exu_rr_pick
   import exu_cal_arb_pkg::*;
#(
   parameter  int NREQ = 3,
   localparam int ID_W = cal_id_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] id
);

   always_comb begin
      logic found;
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      // Outer loop walks the search order; inner loop maps the rotated slot back to a requester.
      for (int i = 0; i < NREQ; i++) begin
         for (int c = 0; c < NREQ; c++) begin
            if (!found && req[c] && (((int'(ptr) + i) % NREQ) == c)) begin
               found  = 1'b1;
               gnt[c] = 1'b1;
               id     = ID_W'(c);
            end
         end
      end
   end

endmodule

// File: rtl/exu_cal_arb.sv
// Shares one multi-cycle calculator among NREQ requesters, one transaction outstanding; grant-to-issue 1 cycle,
// issue held stable under i_cal_rdy backpressure. Define CIRNO_CAL_ARB_PRIO_EN for fixed lowest-index priority.
module exu_cal_arb
   import exu_cal_arb_pkg::*;
#(
   parameter  int NREQ  = 3,
   parameter  int OPB_W = `CIRNO_CAL_OPB_SIZE,
   parameter  int RES_W = 32,
   localparam int ID_W  = cal_id_w(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         i_req_val,
   input  logic [NREQ*OPB_W-1:0]   i_req_opb,
   output logic [NREQ-1:0]         o_req_rdy,
   output logic [RES_W-1:0]        o_req_res,
   output logic                    o_cal_val,
   input  logic                    i_cal_rdy,
   output logic [OPB_W-1:0]        o_cal_opb,
   output logic [ID_W-1:0]         o_cal_id,
   input  logic                    i_cal_rsp_val,
   input  logic [RES_W-1:0]        i_cal_rsp_res,
   output logic                    o_busy
);

   cal_arb_state_e   state, state_nxt;
   logic [NREQ-1:0]  pick_gnt;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  start_ptr;
   logic [OPB_W-1:0] pick_opb;
   logic [NREQ-1:0]  cal_gnt;
   logic             grant;
   logic             done;

`ifdef CIRNO_CAL_ARB_PRIO_EN
   assign start_ptr = '0;
`else
   logic [ID_W-1:0] ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant) begin
         ptr <= (int'(pick_id) == NREQ - 1) ? '0 : pick_id + ID_W'(1);
      end
   end

   assign start_ptr = ptr;
`endif

   exu_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req  (i_req_val),
      .ptr  (start_ptr),
      .gnt  (pick_gnt),
      .id   (pick_id)
   );

   always_comb begin
      pick_opb = '0;
      for (int c = 0; c < NREQ; c++) begin
         if (pick_gnt[c]) begin
            pick_opb = i_req_opb[c*OPB_W +: OPB_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ISSUE with accept and response together is a zero-latency calculator: finish without visiting WAIT.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|i_req_val) begin
               grant     = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (i_cal_rdy) begin
               if (i_cal_rsp_val) begin
                  done      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (i_cal_rsp_val) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The winner's opb and id are frozen here so later changes on its request lines cannot disturb the issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_cal_id  <= '0;
         o_cal_opb <= '0;
         cal_gnt   <= '0;
      end else if (grant) begin
         o_cal_id  <= pick_id;
         o_cal_opb <= pick_opb;
         cal_gnt   <= pick_gnt;
      end
   end

   assign o_cal_val = (state == ST_ISSUE);
   assign o_busy    = (state != ST_IDLE);
   assign o_req_rdy = done ? cal_gnt : '0;
   assign o_req_res = done ? i_cal_rsp_res : '0;

endmodule

// File: tb/tb_exu_cal_arb.sv
// Randomised bench for exu_cal_arb against a transaction-level model, plus directed literal scenarios.
module tb_exu_cal_arb;

   localparam int NREQ  = 3;
   localparam int OPB_W = 16;
   localparam int RES_W = 32;
   localparam int ID_W  = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       i_req_val = '0;
   logic [NREQ*OPB_W-1:0] i_req_opb = '0;
   logic [NREQ-1:0]       o_req_rdy;
   logic [RES_W-1:0]      o_req_res;
   logic                  o_cal_val;
   logic                  i_cal_rdy = 1'b0;
   logic [OPB_W-1:0]      o_cal_opb;
   logic [ID_W-1:0]       o_cal_id;
   logic                  i_cal_rsp_val = 1'b0;
   logic [RES_W-1:0]      i_cal_rsp_res = '0;
   logic                  o_busy;

   always #5 clk = ~clk;

   exu_cal_arb #(
      .NREQ  (NREQ),
      .OPB_W (OPB_W),
      .RES_W (RES_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_val     (i_req_val),
      .i_req_opb     (i_req_opb),
      .o_req_rdy     (o_req_rdy),
      .o_req_res     (o_req_res),
      .o_cal_val     (o_cal_val),
      .i_cal_rdy     (i_cal_rdy),
      .o_cal_opb     (o_cal_opb),
      .o_cal_id      (o_cal_id),
      .i_cal_rsp_val (i_cal_rsp_val),
      .i_cal_rsp_res (i_cal_rsp_res),
      .o_busy        (o_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: one outstanding transaction, whether the calculator has taken it, who owns it, next search start.
   bit               m_busy   = 0;
   bit               m_issued = 0;
   int               m_id     = 0;
   logic [OPB_W-1:0] m_opb    = '0;
   int               m_next   = 0;
   bit               m_done   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] req);
      int start;
`ifdef CIRNO_CAL_ARB_PRIO_EN
      start = 0;
`else
      start = m_next;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (req[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_issued = 0; m_id = 0; m_opb = '0; m_next = 0; m_done = 0;
   endtask

   task automatic compare();
      logic [NREQ-1:0] exp_rdy;
      m_done  = m_busy && i_cal_rsp_val && (m_issued || i_cal_rdy);
      exp_rdy = m_done ? NREQ'(1 << m_id) : '0;
      chk("busy",    64'(o_busy),    64'(m_busy));
      chk("cal_val", 64'(o_cal_val), 64'(m_busy && !m_issued));
      chk("cal_id",  64'(o_cal_id),  64'(m_id));
      chk("cal_opb", 64'(o_cal_opb), 64'(m_opb));
      chk("req_rdy", 64'(o_req_rdy), 64'(exp_rdy));
      chk("req_res", 64'(o_req_res), m_done ? 64'(i_cal_rsp_res) : 64'd0);
   endtask

   task automatic model_update();
      int w;
      if (m_busy) begin
         if (m_done) m_busy = 0;
         else if (!m_issued && i_cal_rdy) m_issued = 1;
      end else if (|i_req_val) begin
         w        = model_pick(i_req_val);
         m_busy   = 1;
         m_issued = 0;
         m_id     = w;
         m_opb    = i_req_opb[w*OPB_W +: OPB_W];
         m_next   = (w + 1) % NREQ;
      end
   endtask

   // Drive one cycle's inputs at the falling edge, check settled outputs, then advance the model past the rising edge.
   task automatic step(input logic [NREQ-1:0] rv, input logic [NREQ*OPB_W-1:0] ro,
                       input logic cr, input logic sv, input logic [RES_W-1:0] sr);
      @(negedge clk);
      i_req_val = rv; i_req_opb = ro; i_cal_rdy = cr; i_cal_rsp_val = sv; i_cal_rsp_res = sr;
      #1;
      compare();
      model_update();
   endtask

   task automatic do_reset(input logic keep_rsp);
      @(negedge clk);
      #2;
      rst = 1'b1; i_req_val = '0; i_cal_rdy = 1'b0; i_cal_rsp_val = keep_rsp; i_cal_rsp_res = 32'hFFFF_0000;
      #1;
      model_reset();
      compare();
      chk("rst_busy",    64'(o_busy),    64'd0);
      chk("rst_req_rdy", 64'(o_req_rdy), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   logic [NREQ-1:0] rr_exp [4];

   initial begin
`ifdef CIRNO_CAL_ARB_PRIO_EN
      rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
      // Reset state
      #3;
      compare();
      chk("init_cal_val", 64'(o_cal_val), 64'd0);
      chk("init_cal_opb", 64'(o_cal_opb), 64'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Single request from requester 1, calculator accepts next cycle, responds the cycle after
      step(3'b010, {16'h0, 16'hBEEF, 16'h0}, 1'b0, 1'b0, '0);
      chk("t1_c0_cal_val", 64'(o_cal_val), 64'd0);
      step(3'b000, '0, 1'b1, 1'b0, '0);
      chk("t1_c1_cal_val", 64'(o_cal_val), 64'd1);
      chk("t1_c1_cal_id",  64'(o_cal_id),  64'd1);
      chk("t1_c1_cal_opb", 64'(o_cal_opb), 64'hBEEF);
      step(3'b000, '0, 1'b0, 1'b1, 32'h1234);
      chk("t1_c2_req_rdy", 64'(o_req_rdy), 64'b010);
      chk("t1_c2_req_res", 64'(o_req_res), 64'h1234);
      step(3'b000, '0, 1'b0, 1'b0, '0);
      chk("t1_c3_busy", 64'(o_busy), 64'd0);

      // All requesting with a zero-latency calculator: completions every other cycle
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         step(3'b111, {16'h2222, 16'h1111, 16'h0000}, 1'b1, 1'b1, 32'(k + 100));
         chk("rr_grant_cycle_rdy", 64'(o_req_rdy), 64'd0);
         step(3'b111, {16'h2222, 16'h1111, 16'h0000}, 1'b1, 1'b1, 32'(k + 100));
         chk("rr_order",       64'(o_req_rdy), 64'(rr_exp[k]));
         chk("rr_res",         64'(o_req_res), 64'(k + 100));
         chk("rr_same_cycle",  64'(o_cal_val), 64'd1);
      end

      // Backpressure: calculator stalls four cycles while the winner withdraws its request
      do_reset(1'b0);
      step(3'b001, {32'h0, 16'hA5C3}, 1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) begin
         step(3'b000, 48'(k * 7), 1'b0, 1'b0, '0);
         chk("bp_cal_val", 64'(o_cal_val), 64'd1);
         chk("bp_cal_id",  64'(o_cal_id),  64'd0);
         chk("bp_cal_opb", 64'(o_cal_opb), 64'hA5C3);
         chk("bp_req_rdy", 64'(o_req_rdy), 64'd0);
      end
      step(3'b000, '0, 1'b1, 1'b1, 32'hCAFE);
      chk("bp_done_rdy", 64'(o_req_rdy), 64'b001);

      // Reset while waiting on the calculator, then a stale response
      step(3'b100, {16'h7777, 32'h0}, 1'b0, 1'b0, '0);
      step(3'b000, '0, 1'b1, 1'b0, '0);
      chk("rw_wait_busy", 64'(o_busy), 64'd1);
      do_reset(1'b1);
      step(3'b000, '0, 1'b0, 1'b1, 32'hDEAD);
      chk("rw_late_rsp_rdy", 64'(o_req_rdy), 64'd0);
      chk("rw_late_rsp_busy", 64'(o_busy), 64'd0);

      // Randomised traffic with varying request density and calculator timing
      for (int c = 0; c < 3000; c++) begin
         logic [NREQ-1:0] rv;
         int dens;
         dens = (c / 500) % 3;
         rv   = NREQ'($urandom);
         if (dens == 0) rv = rv & NREQ'($urandom);
         if (dens == 2) rv = rv | NREQ'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1'($urandom));
         end else begin
            step(rv, 48'({$urandom(), $urandom()}), ($urandom_range(0, 2) != 0),
                 1'($urandom), $urandom());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
